fnd_display_ctrl: RTL and testbench
===================================

Name: fnd_display_ctrl

Overview:
- Consumes the 14-bit stopwatch/counter value (0..9999) and drives a 4-digit common-anode 7-segment display by time-multiplexing.
- Binary-to-BCD conversion is a sequential shift-add-3 (double-dabble) engine. It is retriggered whenever the input value changes.
- A scan divider rotates the digit select. Segment and common outputs are registered and active-low.
- Sits between the counter and the board FND pins.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SCAN_HZ, 1000, per-digit scan rate; the divider terminal count is CLK_HZ/SCAN_HZ-1.
- BLANK_LEADING, 1, when 1 suppresses leading zeros on digits 3..1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- count  in  14  binary value to display; legal range 0..9999.
- dp_en  in  4  decimal point enable per digit; bit i maps to digit i, with digit 0 rightmost.
- fnd_com  out  4  digit commons, active-low, one-hot-low when driving.
- fnd_data  out  8  segments, active-low; bit7=dp, bits6..0=g..a.
- busy  out  1  high while the BCD conversion is in progress.

Behaviour:
- Reset (async): fnd_com=4'b1111, fnd_data=8'hFF, busy=0, digit_sel=0, scan divider=0, captured value=0, displayed BCD=0000, FSM=IDLE.
- Conversion FSM states: IDLE, SHIFT, LATCH.
  - IDLE: if count != captured, capture count, clear scratch BCD, set iteration=0, go to SHIFT. busy goes high the same edge.
  - SHIFT: one double-dabble step per clock. Add 3 to each BCD nibble >=5, then shift left 1 with the next binary MSB. Exactly 14 cycles, then go to LATCH.
  - LATCH: copy scratch BCD to displayed BCD, busy=0, return to IDLE.
  - Latency: displayed BCD reflects a new count exactly 16 clocks after the edge on which count first differs (1 capture + 14 shift + 1 latch).
- count changing during SHIFT/LATCH: the running conversion completes with the captured value. IDLE then sees a mismatch and restarts on the next cycle. No abort.
- count > 9999: no BCD conversion is run. The captured value updates and displayed BCD is marked invalid. All four digits show '-' (8'hBF, dp per dp_en) until a legal value is converted. busy stays 0 for out-of-range captures.
- Scan divider:
  - Counts 0..CLK_HZ/SCAN_HZ-1. At the terminal count it wraps to 0 and digit_sel increments mod 4 (3 -> 0).
- Output register:
  - Every clock (not in reset), fnd_com = ~(1<<digit_sel).
  - fnd_data = segment code of displayed digit[digit_sel], with bit7 = ~dp_en[digit_sel].
  - Output latency is 1 clock from digit_sel/BCD change.
- Segment codes, active-low, bits6..0:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 '-':3F blank:7F.
  - With dp off these are C0 F9 A4 B0 99 92 82 F8 80 90 BF FF.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i in 3..1 is blank if it and all higher digits are 0. Digit 0 is never blanked.
  - dp still honours dp_en on blanked digits.
  - With BLANK_LEADING=0, all digits show their numeral.
- Reset mid-conversion: FSM returns to IDLE and displayed BCD returns to 0000. After release, if count != 0 a fresh conversion starts on the first clock.
- Only a single clock domain is used. count is synchronous to clk.

Test Plan:
1. CLK_HZ=1000, SCAN_HZ=100, count=0, dp_en=0, release reset.
   - 1 clk after release: fnd_com=1110, fnd_data=C0.
   - Every 10 clks fnd_com rotates 1101,1011,0111,1110; digits 3..1 show FF (blanked).
   - fnd_com=1111 and fnd_data=FF while reset is held.
2. Set count=1234.
   - busy rises next edge and stays high 15 clks.
   - Displayed BCD=1234 exactly 16 clks after the change; digits 0..3 show 99,B0,A4,F9.
3. Set count=9999, then change to 0005 while busy.
   - First conversion latches 9999 (90 on all digits).
   - A second conversion starts the cycle after LATCH and ends at 0005: digit0=92, others FF.
4. Set count=12000.
   - No busy pulse; all digits show BF.
   - Then count=42 -> digits 0,1 show A4,99 and digits 2,3 show FF.
5. Set BLANK_LEADING=0, count=7, dp_en=0010.
   - Digits show 0,0,0,7 (C0,C0,C0,F8).
   - Digit1 fnd_data=40 (dp on).
6. Assert reset for 1 clk mid-SHIFT converting 5678.
   - Outputs go to 1111/FF asynchronously.
   - After release, conversion restarts and displays 5678 16 clks later.

Source files
------------

// File: rtl/fnd_display_ctrl.sv
// 4-digit common-anode 7-segment driver with a sequential
// double-dabble BCD converter and a time-multiplexed digit scan.
module fnd_display_ctrl #(
  parameter int CLK_HZ        = 100000000,
  parameter int SCAN_HZ       = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] count,
  input  logic [3:0]  dp_en,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data,
  output logic        busy
);

  localparam int DIV_MAX = CLK_HZ / SCAN_HZ - 1;
  localparam int DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DW-1:0] DIV_TC = DW'(DIV_MAX);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_e;

  state_e state_q, state_d;

  logic [13:0]   cap_q, cap_d;
  logic [13:0]   bin_q, bin_d;
  logic [15:0]   scr_q, scr_d;
  logic [3:0]    iter_q, iter_d;
  logic [15:0]   disp_q, disp_d;
  logic          inv_q, inv_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    com_q, com_d;
  logic [7:0]    data_q, data_d;

  logic          legal;
  logic          diff;
  logic [15:0]   adj;
  logic          tc;
  logic [3:0]    digit;
  logic          z3, z2, z1;
  logic          blank;
  logic [6:0]    seg;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign legal = (count <= 14'd9999);
  assign diff  = (count != cap_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (diff && legal) state_d = SHIFT;
      SHIFT:   if (iter_q == 4'd13) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign adj = {add3(scr_q[15:12]), add3(scr_q[11:8]),
                add3(scr_q[7:4]), add3(scr_q[3:0])};

  always_comb begin
    cap_d  = cap_q;
    bin_d  = bin_q;
    scr_d  = scr_q;
    iter_d = iter_q;
    disp_d = disp_q;
    inv_d  = inv_q;
    busy_d = busy_q;
    unique case (state_q)
      IDLE: begin
        if (diff) begin
          cap_d = count;
          // Out-of-range values skip conversion and just flag dashes.
          if (legal) begin
            bin_d  = count;
            scr_d  = '0;
            iter_d = '0;
            busy_d = 1'b1;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        scr_d  = (adj << 1) | {15'd0, bin_q[13]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + 4'd1;
      end
      LATCH: begin
        disp_d = scr_q;
        inv_d  = 1'b0;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign tc    = (div_q == DIV_TC);
  assign div_d = tc ? '0 : div_q + DW'(1);
  assign sel_d = tc ? sel_q + 2'd1 : sel_q;

  assign digit = disp_q[{sel_q, 2'b00} +: 4];
  assign z3    = (disp_q[15:12] == 4'd0);
  assign z2    = z3 && (disp_q[11:8] == 4'd0);
  assign z1    = z2 && (disp_q[7:4] == 4'd0);

  always_comb begin
    blank = 1'b0;
    case (sel_q)
      2'd3:    blank = z3;
      2'd2:    blank = z2;
      2'd1:    blank = z1;
      default: blank = 1'b0;
    endcase
    blank = blank && BLANK_LEADING;
  end

  always_comb begin
    seg = seg7(digit);
    if (inv_q)      seg = 7'h3F;
    else if (blank) seg = 7'h7F;
    data_d = {~dp_en[sel_q], seg};
    com_d  = ~(4'b0001 << sel_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q  <= '0;
      bin_q  <= '0;
      scr_q  <= '0;
      iter_q <= '0;
      disp_q <= '0;
      inv_q  <= 1'b0;
      busy_q <= 1'b0;
      div_q  <= '0;
      sel_q  <= '0;
      com_q  <= 4'hF;
      data_q <= 8'hFF;
    end else begin
      cap_q  <= cap_d;
      bin_q  <= bin_d;
      scr_q  <= scr_d;
      iter_q <= iter_d;
      disp_q <= disp_d;
      inv_q  <= inv_d;
      busy_q <= busy_d;
      div_q  <= div_d;
      sel_q  <= sel_d;
      com_q  <= com_d;
      data_q <= data_d;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// Bench for fnd_display_ctrl: directed steps plus random values,
// checked against an arithmetic digit/segment reference.
module tb_fnd_display_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] count;
  logic [3:0]  dp_en;
  logic [3:0]  com_a, com_b;
  logic [7:0]  data_a, data_b;
  logic        busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  fnd_display_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_LEADING(1'b1)) u_a (
    .clk(clk), .reset(reset), .count(count), .dp_en(dp_en),
    .fnd_com(com_a), .fnd_data(data_a), .busy(busy_a)
  );

  fnd_display_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_LEADING(1'b0)) u_b (
    .clk(clk), .reset(reset), .count(count), .dp_en(dp_en),
    .fnd_com(com_b), .fnd_data(data_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release: drives the expected scan position.
  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int v, input bit inv,
                                          input logic [3:0] dp, input int d,
                                          input bit blank_en);
    int p;
    logic [6:0] s;
    p = (d == 0) ? 1 : (d == 1) ? 10 : (d == 2) ? 100 : 1000;
    if (inv)                          s = 7'h3F;
    else if (blank_en && d > 0 && v < p) s = 7'h7F;
    else                              s = SEG[(v / p) % 10];
    return {~dp[d], s};
  endfunction

  task automatic check_reset_out(input string tag);
    chk({tag, "_com"}, {4'h0, com_a}, 8'h0F);
    chk({tag, "_data"}, data_a, 8'hFF);
    chk({tag, "_busy"}, {7'd0, busy_a}, 8'h00);
    chk({tag, "_data_b"}, data_b, 8'hFF);
  endtask

  // One full rotation (4 digits x 10 clocks) of both instances.
  task automatic check_scan(input string tag, input int v, input bit inv);
    int sel;
    logic [3:0] ec;
    for (int i = 0; i < 40; i++) begin
      tick();
      sel = ((ecnt - 1) / 10) % 4;
      ec  = ~(4'b0001 << sel);
      chk({tag, "_com"}, {4'h0, com_a}, {4'h0, ec});
      chk({tag, "_data"}, data_a, exp_data(v, inv, dp_en, sel, 1'b1));
      chk({tag, "_data_nb"}, data_b, exp_data(v, inv, dp_en, sel, 1'b0));
    end
  endtask

  // Busy high for 15 samples after the capture edge, for legal values only.
  task automatic watch_busy(input string tag, input bit legal);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk({tag, "_busy"}, {7'd0, busy_a}, {7'd0, legal && i <= 15});
    end
    tick();
  endtask

  initial begin
    int v;
    int prev;
    int sel;
    bit lg;

    reset = 1'b1;
    count = '0;
    dp_en = '0;
    repeat (3) begin
      tick();
      check_reset_out("rst_hold");
    end
    reset = 1'b0;
    tick();
    chk("first_com", {4'h0, com_a}, 8'h0E);
    chk("first_data", data_a, 8'hC0);
    check_scan("zero", 0, 1'b0);

    count = 14'd1234;
    watch_busy("c1234", 1'b1);
    check_scan("v1234", 1234, 1'b0);

    count = 14'd9999;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("c9999_busy", {7'd0, busy_a}, {7'd0, i <= 15});
      if (i == 5) count = 14'd5;
    end
    for (int i = 17; i <= 31; i++) begin
      tick();
      sel = ((ecnt - 1) / 10) % 4;
      chk("c5_busy", {7'd0, busy_a}, 8'h01);
      chk("v9999_data", data_a, exp_data(9999, 1'b0, dp_en, sel, 1'b1));
    end
    tick();
    chk("c5_busy_end", {7'd0, busy_a}, 8'h00);
    tick();
    check_scan("v5", 5, 1'b0);

    count = 14'd12000;
    watch_busy("c12000", 1'b0);
    check_scan("inv", 0, 1'b1);

    count = 14'd42;
    watch_busy("c42", 1'b1);
    check_scan("v42", 42, 1'b0);

    count = 14'd7;
    dp_en = 4'b0010;
    watch_busy("c7", 1'b1);
    check_scan("v7", 7, 1'b0);

    dp_en = 4'b0000;
    count = 14'd5678;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check_reset_out("rst_async");
    tick();
    tick();
    check_reset_out("rst_mid");
    reset = 1'b0;
    watch_busy("c5678", 1'b1);
    check_scan("v5678", 5678, 1'b0);

    prev = 5678;
    for (int r = 0; r < 8; r++) begin
      do begin
        if ($urandom_range(0, 3) == 0) v = $urandom_range(10000, 16383);
        else                           v = $urandom_range(0, 9999);
      end while (v == prev);
      lg    = (v <= 9999);
      count = v[13:0];
      dp_en = 4'($urandom_range(0, 15));
      watch_busy("rnd", lg);
      check_scan("rnd", v, !lg);
      prev = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
